snoop_bus_arbiter: RTL and testbench

Parametrised snooping-coherence bus controller for the multicore processor. It generalises the two-core bus to NUM_CPUS cores, using round-robin arbitration, MSI snoop resolution, cache-to-cache forwarding, modified-line writeback and a handshaked shared data-memory port. It sits between the per-core cache controllers and the shared data memory at the top of the SMP design.

---
 rtl/smp_pkg.sv | 27 ++
 rtl/rr_arbiter.sv | 34 +++
 rtl/snoop_bus_arbiter.sv | 159 +++++++++++++++
 tb/tb_snoop_bus_arbiter.sv | 295 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/smp_pkg.sv
// Shared types for the snooping-coherence bus: block states, bus ops and
// the bus controller FSM encoding.
package smp_pkg;

   typedef enum logic [1:0] {
      INVALID  = 2'b00,
      SHARED   = 2'b01,
      MODIFIED = 2'b10
   } blk_state_t;

   typedef enum logic [1:0] {
      OP_RD  = 2'b00,
      OP_WR  = 2'b01,
      OP_UPG = 2'b10
   } bus_op_t;

   typedef enum logic [2:0] {
      IDLE  = 3'd0,
      SNOOP = 3'd1,
      RESP  = 3'd2,
      WB    = 3'd3,
      MEM   = 3'd4,
      INV   = 3'd5,
      DONE  = 3'd6
   } bus_state_t;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin pick: first requester at or after last_grant+1,
// wrapping modulo N.
module rr_arbiter #(
   parameter int N  = 4,
   parameter int IW = (N > 1) ? $clog2(N) : 1
) (
   input  logic [N-1:0]  req,
   input  logic [IW-1:0] last_grant,
   output logic [N-1:0]  pick,
   output logic [IW-1:0] idx
);

   logic          found;
   int unsigned   cand;
   logic [IW-1:0] cand_idx;

   always_comb begin
      pick     = '0;
      idx      = '0;
      found    = 1'b0;
      cand     = 0;
      cand_idx = '0;
      for (int i = 1; i <= N; i++) begin
         cand     = (int'(last_grant) + i) % N;
         cand_idx = IW'(cand);
         if (!found && req[cand_idx]) begin
            found          = 1'b1;
            pick[cand_idx] = 1'b1;
            idx            = cand_idx;
         end
      end
   end

endmodule

// File: rtl/snoop_bus_arbiter.sv
// MSI snooping bus controller: round-robin ownership, snoop resolution,
// cache-to-cache forwarding with writeback, and a handshaked memory port.
//
// state | meaning
// IDLE  | arbitrate; latch owner, op and address
// SNOOP | broadcast snoop_req to every core except the owner
// RESP  | collect snoop responses, choose data source
// WB    | write back the MODIFIED holder's line, wait for mem_rdy
// MEM   | read the line from memory, wait for mem_rdy
// INV   | invalidate sharers (write miss / upgrade)
// DONE  | pulse done to the owner, update round-robin pointer
module snoop_bus_arbiter
   import smp_pkg::*;
#(
   parameter int NUM_CPUS = 4,
   parameter int ADDR_W   = 13,
   parameter int SEL_W    = $clog2(NUM_CPUS + 1)
) (
   input  logic                       clk,
   input  logic                       rst_n,
   input  logic [NUM_CPUS-1:0]        read_miss,
   input  logic [NUM_CPUS-1:0]        write_miss,
   input  logic [NUM_CPUS-1:0]        upgrade,
   input  logic [NUM_CPUS*ADDR_W-1:0] req_addr,
   input  logic [NUM_CPUS-1:0]        snoop_found,
   input  logic [NUM_CPUS*2-1:0]      snoop_state,
   input  logic                       mem_rdy,
   output logic [NUM_CPUS-1:0]        grant,
   output logic [NUM_CPUS-1:0]        done,
   output logic [ADDR_W-1:0]          snoop_addr,
   output logic [NUM_CPUS-1:0]        snoop_req,
   output logic [NUM_CPUS-1:0]        inv_out,
   output logic [SEL_W-1:0]           data_sel,
   output logic [SEL_W-1:0]           wb_src,
   output logic                       mem_re,
   output logic                       mem_we,
   output logic [ADDR_W-1:0]          mem_addr
);

   localparam int IDX_W = (NUM_CPUS > 1) ? $clog2(NUM_CPUS) : 1;

   bus_state_t          state;
   bus_op_t             op;
   logic [IDX_W-1:0]    owner;
   logic [IDX_W-1:0]    last_grant;
   logic [NUM_CPUS-1:0] sharers;
   logic [NUM_CPUS-1:0] req;
   logic [NUM_CPUS-1:0] pick;
   logic [IDX_W-1:0]    pick_idx;
   logic [NUM_CPUS-1:0] resp_sharers;
   logic                mod_found;
   logic [SEL_W-1:0]    mod_idx;

   assign req      = read_miss | write_miss | upgrade;
   assign mem_addr = snoop_addr;

   rr_arbiter #(.N(NUM_CPUS), .IW(IDX_W)) u_rr_arbiter (
      .req        (req),
      .last_grant (last_grant),
      .pick       (pick),
      .idx        (pick_idx)
   );

   // grant is one-hot on the owner while busy, so it doubles as the owner mask.
   always_comb begin
      resp_sharers = '0;
      mod_found    = 1'b0;
      mod_idx      = '0;
      for (int i = 0; i < NUM_CPUS; i++) begin
         if (snoop_found[i] && !grant[i]) begin
            if (snoop_state[2*i +: 2] == SHARED || snoop_state[2*i +: 2] == MODIFIED)
               resp_sharers[i] = 1'b1;
            if (snoop_state[2*i +: 2] == MODIFIED && !mod_found) begin
               mod_found = 1'b1;
               mod_idx   = SEL_W'(i);
            end
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state      <= IDLE;
         op         <= OP_RD;
         owner      <= '0;
         last_grant <= IDX_W'(NUM_CPUS - 1);
         sharers    <= '0;
         grant      <= '0;
         done       <= '0;
         snoop_addr <= '0;
         snoop_req  <= '0;
         inv_out    <= '0;
         data_sel   <= SEL_W'(NUM_CPUS);
         wb_src     <= '0;
         mem_re     <= 1'b0;
         mem_we     <= 1'b0;
      end else begin
         done      <= '0;
         snoop_req <= '0;
         inv_out   <= '0;
         case (state)
            IDLE: begin
               if (|req) begin
                  owner      <= pick_idx;
                  grant      <= pick;
                  snoop_req  <= ~pick;
                  snoop_addr <= req_addr[pick_idx*ADDR_W +: ADDR_W];
                  if (write_miss[pick_idx])     op <= OP_WR;
                  else if (read_miss[pick_idx]) op <= OP_RD;
                  else                          op <= OP_UPG;
                  state <= SNOOP;
               end
            end
            SNOOP: state <= RESP;
            RESP: begin
               sharers <= resp_sharers;
               if (op == OP_UPG) begin
                  data_sel <= SEL_W'(NUM_CPUS);
                  inv_out  <= resp_sharers;
                  state    <= INV;
               end else if (mod_found) begin
                  data_sel <= mod_idx;
                  wb_src   <= mod_idx;
                  mem_we   <= 1'b1;
                  state    <= WB;
               end else begin
                  data_sel <= SEL_W'(NUM_CPUS);
                  mem_re   <= 1'b1;
                  state    <= MEM;
               end
            end
            WB, MEM: begin
               if (mem_rdy) begin
                  mem_we <= 1'b0;
                  mem_re <= 1'b0;
                  if (op == OP_WR) begin
                     inv_out <= sharers;
                     state   <= INV;
                  end else begin
                     done  <= grant;
                     state <= DONE;
                  end
               end
            end
            INV: begin
               done  <= grant;
               state <= DONE;
            end
            DONE: begin
               grant      <= '0;
               last_grant <= owner;
               state      <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_snoop_bus_arbiter.sv
// Self-checking bench for snoop_bus_arbiter: directed scenarios plus
// randomized transactions checked against a cycle-timeline reference model.
module tb_snoop_bus_arbiter;

   localparam int N  = 4;
   localparam int AW = 13;
   localparam int SW = 3;

   logic            clk = 1'b0;
   logic            rst_n;
   logic [N-1:0]    read_miss, write_miss, upgrade;
   logic [N*AW-1:0] req_addr;
   logic [N-1:0]    snoop_found;
   logic [2*N-1:0]  snoop_state;
   logic            mem_rdy;
   logic [N-1:0]    grant, done, snoop_req, inv_out;
   logic [AW-1:0]   snoop_addr, mem_addr;
   logic [SW-1:0]   data_sel, wb_src;
   logic            mem_re, mem_we;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   snoop_bus_arbiter #(.NUM_CPUS(N), .ADDR_W(AW), .SEL_W(SW)) dut (
      .clk(clk), .rst_n(rst_n),
      .read_miss(read_miss), .write_miss(write_miss), .upgrade(upgrade),
      .req_addr(req_addr), .snoop_found(snoop_found), .snoop_state(snoop_state),
      .mem_rdy(mem_rdy), .grant(grant), .done(done), .snoop_addr(snoop_addr),
      .snoop_req(snoop_req), .inv_out(inv_out), .data_sel(data_sel),
      .wb_src(wb_src), .mem_re(mem_re), .mem_we(mem_we), .mem_addr(mem_addr)
   );

   // Model: derive the whole expected output timeline from the latency rules,
   // then compare cycle by cycle (cycle 0 = IDLE cycle that sees the request).
   task automatic run_txn(input string name, input int core, input logic wm,
                          input logic rm, input logic up, input logic [AW-1:0] addr,
                          input logic [N-1:0] fnd, input logic [2*N-1:0] st,
                          input int waits);
      logic [N-1:0] me, sh;
      logic [N-1:0] e_snp [16], e_gnt [16], e_done [16], e_inv [16];
      logic         e_re [16], e_we [16];
      logic [1:0]   s;
      logic [SW-1:0] e_sel;
      int modc, done_c, inv_c, wcnt;
      bit is_wr, is_up;
      me    = 4'b0001 << core;
      is_wr = wm;
      is_up = !wm && !rm && up;
      sh    = '0;
      modc  = -1;
      for (int i = 0; i < N; i++) begin
         if (i != core && fnd[i]) begin
            s = st[2*i +: 2];
            if (s == 2'b01 || s == 2'b10) sh[i] = 1'b1;
            if (s == 2'b10 && modc < 0) modc = i;
         end
      end
      if (is_up) begin
         inv_c = 3; done_c = 4;
      end else begin
         inv_c  = is_wr ? 4 + waits : -1;
         done_c = is_wr ? 5 + waits : 4 + waits;
      end
      e_sel = (modc < 0) ? SW'(N) : SW'(modc);
      for (int k = 0; k < 16; k++) begin
         e_snp[k]  = (k == 1) ? ~me : '0;
         e_gnt[k]  = (k >= 1 && k <= done_c) ? me : '0;
         e_done[k] = (k == done_c) ? me : '0;
         e_inv[k]  = (k == inv_c) ? sh : '0;
         e_re[k]   = !is_up && modc < 0  && k >= 3 && k <= 3 + waits;
         e_we[k]   = !is_up && modc >= 0 && k >= 3 && k <= 3 + waits;
      end

      @(negedge clk);
      req_addr = {$urandom, $urandom};
      req_addr[core*AW +: AW] = addr;
      snoop_found = fnd;
      snoop_state = st;
      write_miss = '0; read_miss = '0; upgrade = '0;
      write_miss[core] = wm;
      read_miss[core]  = rm;
      upgrade[core]    = up;
      wcnt = 0;
      for (int k = 1; k <= done_c + 1; k++) begin
         @(negedge clk);
         if (mem_re || mem_we) begin
            mem_rdy = (wcnt == waits);
            wcnt++;
         end else begin
            mem_rdy = 1'($urandom_range(0, 1));
         end
         checks++;
         if (snoop_req !== e_snp[k]) begin
            errors++;
            $display("FAIL %s snoop_req cycle %0d got %b expected %b", name, k, snoop_req, e_snp[k]);
         end
         checks++;
         if (grant !== e_gnt[k]) begin
            errors++;
            $display("FAIL %s grant cycle %0d got %b expected %b", name, k, grant, e_gnt[k]);
         end
         checks++;
         if (done !== e_done[k]) begin
            errors++;
            $display("FAIL %s done cycle %0d got %b expected %b", name, k, done, e_done[k]);
         end
         checks++;
         if (inv_out !== e_inv[k]) begin
            errors++;
            $display("FAIL %s inv_out cycle %0d got %b expected %b", name, k, inv_out, e_inv[k]);
         end
         checks++;
         if (mem_re !== e_re[k] || mem_we !== e_we[k]) begin
            errors++;
            $display("FAIL %s mem_re/we cycle %0d got %b%b expected %b%b", name, k,
                     mem_re, mem_we, e_re[k], e_we[k]);
         end
         if (!is_up && k >= 3 && k <= done_c) begin
            checks++;
            if (data_sel !== e_sel) begin
               errors++;
               $display("FAIL %s data_sel cycle %0d got %0d expected %0d", name, k, data_sel, e_sel);
            end
            if (modc >= 0) begin
               checks++;
               if (wb_src !== e_sel) begin
                  errors++;
                  $display("FAIL %s wb_src cycle %0d got %0d expected %0d", name, k, wb_src, e_sel);
               end
            end
         end
         if (k == done_c) begin
            checks++;
            if (snoop_addr !== addr || mem_addr !== addr) begin
               errors++;
               $display("FAIL %s addr got %h/%h expected %h", name, snoop_addr, mem_addr, addr);
            end
            write_miss = '0; read_miss = '0; upgrade = '0;
         end
      end
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      read_miss = '0; write_miss = '0; upgrade = '0;
      req_addr = '0; snoop_found = '0; snoop_state = '0; mem_rdy = 1'b0;
      #12;
      checks++;
      if ({grant, done, snoop_req, inv_out, mem_re, mem_we, snoop_addr, mem_addr, data_sel, wb_src}
          !== {16'h0, 2'b00, 26'h0, 3'd4, 3'd0}) begin
         errors++;
         $display("FAIL reset_outputs got g%b d%b s%b i%b re%b we%b a%h ds%0d wb%0d", grant, done,
                  snoop_req, inv_out, mem_re, mem_we, snoop_addr, data_sel, wb_src);
      end
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      checks++;
      if (grant !== 4'b0 || snoop_req !== 4'b0 || data_sel !== 3'd4) begin
         errors++;
         $display("FAIL reset_idle got g%b s%b ds%0d expected 0 0 4", grant, snoop_req, data_sel);
      end
   endtask

   task automatic test_read_miss();
      run_txn("read_miss", 2, 1'b0, 1'b1, 1'b0, 13'h0A5, 4'b0000, 8'h00, 0);
   endtask

   task automatic test_write_miss_modified();
      run_txn("wm_modified", 0, 1'b1, 1'b0, 1'b0, 13'h123, 4'b1000, 8'b10_00_00_00, 2);
   endtask

   task automatic test_upgrade();
      // Owner core 1 also reports MODIFIED; that response must be masked.
      run_txn("upgrade", 1, 1'b0, 1'b0, 1'b1, 13'h1F0, 4'b1011, 8'b01_00_10_01, 0);
   endtask

   task automatic test_op_priority();
      run_txn("wm_rm_priority", 2, 1'b1, 1'b1, 1'b0, 13'h055, 4'b0000, 8'h00, 1);
   endtask

   task automatic test_random();
      int ops;
      for (int t = 0; t < 24; t++) begin
         ops = $urandom_range(1, 7);
         run_txn("random", $urandom_range(0, N-1), ops[0], ops[1], ops[2],
                 AW'($urandom), N'($urandom), (2*N)'($urandom), $urandom_range(0, 3));
      end
   endtask

   task automatic test_round_robin();
      int ndone, expc;
      @(negedge clk);
      rst_n = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      snoop_found = '0;
      mem_rdy = 1'b1;
      read_miss = 4'hF;
      ndone = 0;
      expc = 0;
      for (int c = 0; c < 60 && ndone < 6; c++) begin
         @(negedge clk);
         if (done != '0) begin
            checks++;
            if (done !== (4'b0001 << expc)) begin
               errors++;
               $display("FAIL rr_order txn %0d got %b expected %b", ndone, done, 4'b0001 << expc);
            end
            expc = (expc + 1) % N;
            ndone++;
         end
      end
      checks++;
      if (ndone != 6) begin
         errors++;
         $display("FAIL rr_count got %0d expected 6", ndone);
      end
      read_miss = '0;
   endtask

   task automatic test_reset_mid_wb();
      int wbcnt;
      bit seen;
      @(negedge clk);
      write_miss = 4'b0010;
      snoop_found = 4'b1000;
      snoop_state = 8'b10_00_00_00;
      mem_rdy = 1'b0;
      wbcnt = 0;
      for (int k = 0; k < 20 && wbcnt < 3; k++) begin
         @(negedge clk);
         mem_rdy = 1'b0;
         if (mem_we) wbcnt++;
      end
      checks++;
      if (wbcnt != 3) begin
         errors++;
         $display("FAIL wb_reach got %0d wb cycles expected 3", wbcnt);
      end
      rst_n = 1'b0;
      #1;
      checks++;
      if ({grant, done, snoop_req, inv_out, mem_re, mem_we, snoop_addr, mem_addr, data_sel, wb_src}
          !== {16'h0, 2'b00, 26'h0, 3'd4, 3'd0}) begin
         errors++;
         $display("FAIL reset_mid_wb got g%b d%b s%b i%b re%b we%b a%h ds%0d wb%0d", grant, done,
                  snoop_req, inv_out, mem_re, mem_we, snoop_addr, data_sel, wb_src);
      end
      write_miss = '0;
      snoop_found = '0;
      @(negedge clk);
      rst_n = 1'b1;
      read_miss = 4'b0101;
      mem_rdy = 1'b1;
      seen = 1'b0;
      for (int k = 0; k < 12 && !seen; k++) begin
         @(negedge clk);
         if (grant != '0) seen = 1'b1;
      end
      checks++;
      if (grant !== 4'b0001) begin
         errors++;
         $display("FAIL post_reset_grant got %b expected 0001", grant);
      end
      seen = 1'b0;
      for (int k = 0; k < 12 && !seen; k++) begin
         @(negedge clk);
         if (done != '0) seen = 1'b1;
      end
      checks++;
      if (done !== 4'b0001) begin
         errors++;
         $display("FAIL post_reset_done got %b expected 0001", done);
      end
      read_miss = '0;
   endtask

   initial begin
      test_reset();
      test_read_miss();
      test_write_miss_modified();
      test_upgrade();
      test_op_priority();
      test_random();
      test_round_robin();
      test_reset_mid_wb();
      repeat (3) @(negedge clk);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
